sw_display_pager: RTL and testbench
===================================

SW_DISPLAY_PAGER -- requirements
Module: sw_display_pager

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_TIME, default 250_000, meaning clock cycles a raw page switch level must stay stable before it is accepted (10 ms @ 25 MHz).
REQ-002 The block SHALL have parameter BLINK_TIME, default 6_250_000, meaning half-period of the paused-display blink in clock cycles (0.25 s @ 25 MHz).
REQ-003 The block SHALL have port i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_Switch_3  input  1  raw, bouncing page-select push button; high = pressed.
REQ-006 The block SHALL have port i_Running  input  1  high while the stopwatch core is counting.
REQ-007 The block SHALL have port i_Digits  input  24  six BCD digits {M1,M0,S1,S0,C1,C0} (minutes, seconds, centiseconds); M1 in [23:20].
REQ-008 The block SHALL have port o_Segments1  output  7  left (tens) display, bit order {G,F,E,D,C,B,A}, active-low (0 = lit).
REQ-009 The block SHALL have port o_Segments2  output  7  right (units) display, same encoding.
REQ-010 The block SHALL have port o_Page  output  2  current page: 0 = centiseconds, 1 = seconds, 2 = minutes.

Function
REQ-011 The debouncer SHALL count while i_Switch_3 differs from the debounced level, clear its counter when they match, and update the debounced level when the counter reaches DEBOUNCE_TIME-1.
REQ-012 The block SHALL register o_Page and advance it on each rising edge of the debounced level, in the order 0 -> 1 -> 2 -> 0; falling edges SHALL have no effect.
REQ-013 o_Page SHALL never take the value 3; if it is ever 3, the next page advance SHALL load 0.
REQ-014 The selected pair SHALL be {C1,C0} on page 0, {S1,S0} on page 1, and {M1,M0} on page 2.
REQ-015 o_Segments1/2 SHALL be registered, with one cycle of latency from i_Digits, o_Page and the blink phase to the outputs.
REQ-016 The decoder SHALL produce these codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-017 A BCD digit greater than 9 SHALL be shown as a dash, 7'h3F.
REQ-018 On page 2 only, an M1 value of 0 SHALL blank o_Segments1 (7'h7F); on pages 0 and 1, a tens digit of 0 SHALL display "0".
REQ-019 The blink logic SHALL count 0..BLINK_TIME-1 and toggle the phase at the terminal count, when i_Running = 0 and i_Digits is non-zero.
REQ-020 During the off phase, both outputs SHALL be 7'h7F.
REQ-021 While i_Running = 1, or while i_Digits = 0, the blink counter SHALL be held at 0 and the phase forced to on, with no blanking.
REQ-022 When i_Running rises during the off phase, the display SHALL reappear on the cycle after next, following the one-cycle output latency.
REQ-023 A page advance during the off phase SHALL update o_Page but SHALL NOT affect the blink phase or the blink counter.
REQ-024 A change of i_Digits on the same cycle as a page advance SHALL produce outputs from the new digits on the new page, one cycle later.

Reset
REQ-025 While i_Rst is high, o_Page SHALL be 0, the debounced level 0, the debounce counter 0, the blink counter 0, the phase on, and o_Segments1 = o_Segments2 = 7'h7F.
REQ-026 A press in progress at reset assertion SHALL be discarded.
REQ-027 After i_Rst is released, a switch already held high SHALL advance the page once, after DEBOUNCE_TIME stable cycles.

Verification (DEBOUNCE_TIME=4, BLINK_TIME=8 in the bench)
REQ-028 Scenario: reset, i_Running=1, i_Digits=24'h012345 -> o_Page=0, o_Segments1=7'h19 ("4") and o_Segments2=7'h12 ("5") one cycle after reset release.
REQ-029 Scenario: i_Switch_3 toggles every 2 cycles for 10 cycles, then is held high for 6 cycles -> exactly one advance, o_Page=1, outputs show "2","3".
REQ-030 Scenario: three clean presses starting from page 0 -> o_Page sequence 1, 2, 0; on page 2 with i_Digits=24'h012345, o_Segments1=7'h7F (blank M1) and o_Segments2=7'h79 ("1").
REQ-031 Scenario: i_Running=0, i_Digits=24'h000001 -> outputs alternate between the digits and 7'h7F every 8 cycles; with i_Digits=24'h000000 -> steady "00", no blanking.
REQ-032 Scenario: i_Digits C0=4'hA, C1=0 on page 0 -> o_Segments2=7'h3F and o_Segments1=7'h40.
REQ-033 Scenario: assert i_Rst mid-debounce (counter=2) during the off phase -> outputs 7'h7F immediately, o_Page=0, and no page advance unless the switch is held for 4 cycles after release.

Source files
------------

// File: rtl/sw_display_pager.sv
// sw_display_pager
//   Chooses which digit pair of a stopwatch is shown on two 7-segment
//   displays. A debounced push button steps through three pages. While the
//   stopwatch is paused with a non-zero time, the display blinks.
//
// Ports
//   i_Clk        system clock, rising edge
//   i_Rst        asynchronous active-high reset
//   i_Switch_3   raw page-select button (high = pressed, bouncing)
//   i_Running    high while the stopwatch is counting
//   i_Digits     {M1,M0,S1,S0,C1,C0} BCD digits
//   o_Segments1  tens display {G,F,E,D,C,B,A}, active-low
//   o_Segments2  units display, same encoding
//   o_Page       0 = centiseconds, 1 = seconds, 2 = minutes
module sw_display_pager #(
  parameter int DEBOUNCE_TIME = 250_000,
  parameter int BLINK_TIME    = 6_250_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Switch_3,
  input  logic        i_Running,
  input  logic [23:0] i_Digits,
  output logic [6:0]  o_Segments1,
  output logic [6:0]  o_Segments2,
  output logic [1:0]  o_Page
);

  localparam int DB_W = (DEBOUNCE_TIME > 1) ? $clog2(DEBOUNCE_TIME) : 1;
  localparam int BL_W = (BLINK_TIME > 1) ? $clog2(BLINK_TIME) : 1;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  logic [DB_W-1:0] db_cnt;
  logic            sw_db;
  logic            sw_db_q;
  logic [BL_W-1:0] blink_cnt;
  logic            phase_on;
  logic            blink_hold;
  logic [3:0]      tens;
  logic [3:0]      units;
  logic [6:0]      seg1_next;
  logic [6:0]      seg2_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // Debouncer: the raw level must differ from the accepted level for
  // DEBOUNCE_TIME consecutive cycles before it is accepted.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      db_cnt  <= '0;
      sw_db   <= 1'b0;
      sw_db_q <= 1'b0;
    end else begin
      sw_db_q <= sw_db;
      if (i_Switch_3 != sw_db) begin
        if (db_cnt == DB_W'(DEBOUNCE_TIME - 1)) begin
          sw_db  <= i_Switch_3;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Page advances one cycle after the debounced level rises. Any value
  // other than 0 or 1 (including the unreachable 3) wraps to 0.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Page <= 2'd0;
    end else if (sw_db && !sw_db_q) begin
      case (o_Page)
        2'd0:    o_Page <= 2'd1;
        2'd1:    o_Page <= 2'd2;
        default: o_Page <= 2'd0;
      endcase
    end
  end

  // Blink only while paused with a non-zero time; otherwise held "on".
  assign blink_hold = i_Running || (i_Digits == 24'd0);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_hold) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BL_W'(BLINK_TIME - 1)) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    tens      = i_Digits[7:4];
    units     = i_Digits[3:0];
    seg1_next = SEG_OFF;
    seg2_next = SEG_OFF;
    case (o_Page)
      2'd1: begin
        tens  = i_Digits[15:12];
        units = i_Digits[11:8];
      end
      2'd2: begin
        tens  = i_Digits[23:20];
        units = i_Digits[19:16];
      end
      default: begin
        tens  = i_Digits[7:4];
        units = i_Digits[3:0];
      end
    endcase
    if (phase_on) begin
      // Leading-zero suppression applies to minutes only.
      seg1_next = ((o_Page == 2'd2) && (tens == 4'd0)) ? SEG_OFF : seg7(tens);
      seg2_next = seg7(units);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Segments1 <= SEG_OFF;
      o_Segments2 <= SEG_OFF;
    end else begin
      o_Segments1 <= seg1_next;
      o_Segments2 <= seg2_next;
    end
  end

endmodule

// File: tb/tb_sw_display_pager.sv
module tb_sw_display_pager;

  localparam int DT = 4;
  localparam int BT = 8;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_Switch_3 = 1'b0;
  logic        i_Running = 1'b1;
  logic [23:0] i_Digits = 24'h012345;
  logic [6:0]  o_Segments1;
  logic [6:0]  o_Segments2;
  logic [1:0]  o_Page;

  sw_display_pager #(.DEBOUNCE_TIME(DT), .BLINK_TIME(BT)) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Switch_3(i_Switch_3),
    .i_Running(i_Running),
    .i_Digits(i_Digits),
    .o_Segments1(o_Segments1),
    .o_Segments2(o_Segments2),
    .o_Page(o_Page)
  );

  // clock / reset
  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_page;
  int m_db;
  int m_run;
  int m_adv;
  int m_age;
  int m_on;
  logic [13:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 9) return 7'h3F;
    return tbl[d];
  endfunction

  // Display image for a page: units digit is nibble 2*page, tens is next.
  function automatic logic [13:0] render(input int page, input int on, input logic [23:0] dig);
    int u;
    int t;
    logic [6:0] s1;
    if (!on) return {7'h7F, 7'h7F};
    u = int'((dig >> (8 * page)) & 24'hF);
    t = int'((dig >> (8 * page + 4)) & 24'hF);
    s1 = (page == 2 && t == 0) ? 7'h7F : seg_of(t);
    return {s1, seg_of(u)};
  endfunction

  task automatic model_reset();
    m_page = 0; m_db = 0; m_run = 0; m_adv = 0; m_age = 0; m_on = 1;
  endtask

  task automatic model_step();
    if (i_Rst) begin
      model_reset();
      exp_q.push_back({7'h7F, 7'h7F});
    end else begin
      exp_q.push_back(render(m_page, m_on, i_Digits));
      if (m_adv != 0) m_page = (m_page + 1) % 3;
      m_adv = 0;
      if (int'(i_Switch_3) != m_db) begin
        m_run++;
        if (m_run == DT) begin
          m_db = int'(i_Switch_3);
          m_run = 0;
          if (m_db == 1) m_adv = 1;
        end
      end else begin
        m_run = 0;
      end
      if (i_Running || i_Digits == 24'd0) begin
        m_age = 0;
        m_on = 1;
      end else begin
        m_age++;
        if (m_age == BT) begin
          m_age = 0;
          m_on = 1 - m_on;
        end
      end
    end
  endtask

  // one clock: model advances on the edge, outputs compared on the falling edge
  task automatic cycle();
    logic [13:0] e;
    @(posedge i_Clk);
    model_step();
    @(negedge i_Clk);
    e = exp_q.pop_front();
    check("page", 32'(o_Page), 32'(m_page));
    check("seg1", 32'(o_Segments1), 32'(e[13:7]));
    check("seg2", 32'(o_Segments2), 32'(e[6:0]));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input int hi, input int lo);
    i_Switch_3 = 1'b1;
    cycles(hi);
    i_Switch_3 = 1'b0;
    cycles(lo);
  endtask

  task automatic apply_reset(input int n);
    i_Rst = 1'b1;
    #1;
    model_reset();
    check("rst_seg1", 32'(o_Segments1), 32'h7F);
    check("rst_seg2", 32'(o_Segments2), 32'h7F);
    check("rst_page", 32'(o_Page), 32'd0);
    cycles(n);
    @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  initial begin
    int hold_left;
    int found;
    model_reset();
    @(negedge i_Clk);

    // reset, running, 012345 -> "45" one cycle after release
    apply_reset(2);
    cycle();
    check("s1_seg1", 32'(o_Segments1), 32'h19);
    check("s1_seg2", 32'(o_Segments2), 32'h12);
    check("s1_page", 32'(o_Page), 32'd0);

    // bouncing switch then held: exactly one advance
    for (int i = 0; i < 5; i++) begin
      i_Switch_3 = ~i_Switch_3;
      cycles(2);
    end
    check("bounce_page", 32'(o_Page), 32'd0);
    i_Switch_3 = 1'b1;
    cycles(6);
    check("held_page", 32'(o_Page), 32'd1);
    check("held_seg1", 32'(o_Segments1), 32'h24);
    check("held_seg2", 32'(o_Segments2), 32'h30);
    i_Switch_3 = 1'b0;
    cycles(6);

    // three clean presses from page 0
    apply_reset(1);
    cycle();
    press(6, 6);
    check("p1", 32'(o_Page), 32'd1);
    press(6, 6);
    check("p2", 32'(o_Page), 32'd2);
    check("p2_seg1", 32'(o_Segments1), 32'h7F);
    check("p2_seg2", 32'(o_Segments2), 32'h79);
    press(6, 6);
    check("p3", 32'(o_Page), 32'd0);

    // dash for an invalid digit, "0" tens on page 0
    i_Digits = 24'h00000A;
    cycles(2);
    check("dash_seg2", 32'(o_Segments2), 32'h3F);
    check("zero_seg1", 32'(o_Segments1), 32'h40);

    // blink while paused; steady when time is zero
    i_Running = 1'b0;
    i_Digits = 24'h000001;
    cycles(40);
    i_Digits = 24'h000000;
    cycles(20);
    check("zero_seg1", 32'(o_Segments1), 32'h40);
    check("zero_seg2", 32'(o_Segments2), 32'h40);

    // running rises in the off phase
    i_Digits = 24'h000001;
    cycles(12);
    i_Running = 1'b1;
    cycles(3);
    i_Running = 1'b0;

    // reset mid-debounce during the off phase
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cycle();
      if (m_on == 0) found = 1;
    end
    check("off_found", 32'(found), 32'd1);
    i_Switch_3 = 1'b1;
    cycles(2);
    apply_reset(2);
    cycles(3);
    i_Switch_3 = 1'b0;
    cycles(4);
    check("discard_page", 32'(o_Page), 32'd0);
    // switch held through reset release advances exactly once
    i_Switch_3 = 1'b1;
    apply_reset(1);
    cycles(8);
    check("held_rst_page", 32'(o_Page), 32'd1);
    i_Switch_3 = 1'b0;
    cycles(6);

    // randomized soak
    hold_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold_left == 0) begin
        i_Switch_3 = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 7);
      end
      hold_left--;
      if ($urandom_range(0, 24) == 0) i_Running = ~i_Running;
      if ($urandom_range(0, 11) == 0)
        i_Digits = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
